udp_recv: RTL
=============

// Module: udp_recv
// PURPOSE
//  Receive-side UDP layer: takes the IP payload stream from the IP receive stage (32-bit AXIS-style, big-endian),
//  parses and strips the 8-byte UDP header, filters on destination port and delivers payload plus metadata to the app.
//  Mirror of the transmit-side udp_send stage; sits between ip_recv and the application, single clock domain.
// PARAMETERS
//  PORT_FILTER  1   1: drop datagrams whose dst port != local_port_in; 0: accept all ports
//  DROP_CNT_W   16  width of saturating drop counter
// PORTS
//  clk             in   1   clock; all logic rising-edge
//  reset           in   1   asynchronous, active-high reset
//  local_port_in   in   16  UDP port accepted when PORT_FILTER=1; sampled at header word 0
//  src_ip_addr_in  in   32  sender IP from ip_recv; sampled with header word 0
//  ip_data_in      in   32  IP payload; byte0 on [31:24]
//  ip_valid_in     in   1   input beat valid
//  ip_keep_in      in   4   byte enables, contiguous from bit 3 (4'b1000..4'b1111)
//  ip_last_in      in   1   last beat of IP payload
//  ip_ready_out    out  1   input beat accepted when valid&ready
//  data_out        out  32  UDP payload to app
//  data_valid_out  out  1   payload beat valid
//  data_keep_out   out  4   payload byte enables
//  data_last_out   out  1   last payload beat
//  data_ready_in   in   1   app back-pressure
//  hdr_valid_out   out  1   1-cycle pulse: metadata below valid for the accepted datagram
//  src_ip_out      out  32  sender IP
//  src_port_out    out  16  UDP source port
//  length_out      out  16  payload bytes = UDP length - 8
//  err_out         out  1   1-cycle pulse on malformed datagram
//  drop_cnt_out    out  DROP_CNT_W  saturating count of dropped datagrams
// BEHAVIOUR
//  Reset: all outputs 0 except ip_ready_out=1 (S_HDR0); FSM -> S_HDR0; counters cleared. Reset mid-packet abandons it;
//   remaining input beats are parsed as a new header (ip_recv is reset together with this block).
//  FSM: S_HDR0 -> S_HDR1 -> S_PAY -> S_HDR0; any state -> S_DROP -> S_HDR0 on accepted ip_last_in.
//  S_HDR0 (ready=1): word = {src_port, dst_port}; latch src_port, src_ip_addr_in; port_ok = !PORT_FILTER | dst==local.
//  S_HDR1 (ready=1): word = {udp_len, checksum}; checksum ignored.
//   udp_len<8, or ip_last_in in HDR0/HDR1 with udp_len>8 -> err_out, drop_cnt++, next S_HDR0 (if last) else S_DROP.
//   !port_ok -> drop_cnt++ (no err), S_DROP (S_HDR0 if last).  Otherwise hdr_valid_out pulse next cycle,
//   length_out=udp_len-8 (16-bit, never wraps since len>=8); go S_PAY, or S_HDR0 if udp_len==8 and last,
//   or S_DROP if udp_len==8 and not last (padding discarded, no err).
//  S_PAY: one registered output stage; ip_ready_out = !data_valid_out | data_ready_in; payload beat latency 1 cycle;
//   data/keep/last held stable while valid&!ready. Last accepted payload beat -> S_HDR0.
//  S_DROP (ready=1): discard beats until ip_last_in accepted; no output activity.
//  hdr_valid_out precedes or coincides with first payload beat; metadata held until next hdr_valid_out.
//  drop_cnt_out saturates at all-ones. err_out and hdr_valid_out never assert in the same cycle.
//  Back-to-back datagrams: new header accepted the cycle after previous last; no bubble required.
// CONFIGURATION
//  UDP_LEN_CHECK_EN defined: 16-bit payload byte counter vs length_out. Beat containing final byte gets
//   data_last_out=1 and keep trimmed (e.g. 1 rem byte -> 4'b1000); later beats (Ethernet padding) discarded via S_DROP
//   with no err. ip_last_in before length reached -> data_last_out on that beat, err_out pulse, drop_cnt unchanged.
//  Not defined: payload forwarded unmodified until ip_last_in; data_keep_out=ip_keep_in; length_out still reported.
// TESTING
//  1 port=0x1F90 match, len=0x000C, payload 0xDEADBEEF last keep=F -> hdr_valid, length_out=4, one beat DEADBEEF last.
//  2 dst port 0x1234 vs local 0x1F90, 3 beats -> no output, drop_cnt 0->1, err_out=0; next good packet passes.
//  3 udp_len=0x0006 -> err_out pulse, drop_cnt++, rest of packet discarded.
//  4 UDP_LEN_CHECK_EN, len=0x000D (5 bytes) + 10 padding bytes -> beats AABBCCDD keep F, EE000000 keep 8 last; pad dropped.
//  5 data_ready_in toggled 0/1 every cycle over 16-beat payload -> no loss/duplication, order and keep preserved.
//  6 reset asserted mid-payload -> outputs 0 immediately, ip_ready_out=1; following packet received correctly.

Source files
------------

// File: rtl/udp_recv.sv
// udp_recv -- receive-side UDP layer.
//
// Accepts the IP payload stream from ip_recv (32-bit, big-endian, byte0 on
// [31:24]), parses and strips the 8-byte UDP header, filters on destination
// port and forwards the UDP payload plus metadata to the application.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   local_port_in                   UDP port accepted when PORT_FILTER=1
//   src_ip_addr_in                  sender IP, sampled with header word 0
//   ip_data/valid/keep/last_in      input stream, ip_ready_out back-pressure
//   data_out/valid/keep/last_out    payload stream, data_ready_in back-pressure
//   hdr_valid_out                   1-cycle pulse, src_ip/src_port/length valid
//   err_out                         1-cycle pulse on malformed datagram
//   drop_cnt_out                    saturating count of dropped datagrams
//
// Optional feature macro: UDP_LEN_CHECK_EN
//   defined   -> payload is trimmed to the UDP length; trailing padding dropped,
//                early ip_last_in flags err_out.
//   undefined -> payload forwarded unmodified until ip_last_in.
module udp_recv #(
    parameter bit PORT_FILTER = 1'b1,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           local_port_in,
    input  logic [31:0]           src_ip_addr_in,
    input  logic [31:0]           ip_data_in,
    input  logic                  ip_valid_in,
    input  logic [3:0]            ip_keep_in,
    input  logic                  ip_last_in,
    output logic                  ip_ready_out,
    output logic [31:0]           data_out,
    output logic                  data_valid_out,
    output logic [3:0]            data_keep_out,
    output logic                  data_last_out,
    input  logic                  data_ready_in,
    output logic                  hdr_valid_out,
    output logic [31:0]           src_ip_out,
    output logic [15:0]           src_port_out,
    output logic [15:0]           length_out,
    output logic                  err_out,
    output logic [DROP_CNT_W-1:0] drop_cnt_out
);

    typedef enum logic [1:0] {S_HDR0, S_HDR1, S_PAY, S_DROP} state_t;

    state_t                state_q, state_d;
    logic [15:0]           pend_port_q, pend_port_d;
    logic [31:0]           pend_ip_q, pend_ip_d;
    logic                  port_ok_q, port_ok_d;
    logic [31:0]           src_ip_q, src_ip_d;
    logic [15:0]           src_port_q, src_port_d;
    logic [15:0]           length_q, length_d;
    logic                  hdr_valid_q, hdr_valid_d;
    logic                  err_q, err_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  dvalid_q, dvalid_d;
    logic                  drop_inc;
    logic                  accept;
    logic [15:0]           udp_len;
    logic [31:0]           pay_data;
    logic [3:0]            pay_keep;

`ifdef UDP_LEN_CHECK_EN
    logic [15:0] rem_q, rem_d;
    logic [15:0] beat_bytes;
    logic        final_hit;
    logic [31:0] byte_mask;

    // Beat containing the final UDP byte: trim keep to the remaining count.
    always_comb begin
        case (ip_keep_in)
            4'b1000: beat_bytes = 16'd1;
            4'b1100: beat_bytes = 16'd2;
            4'b1110: beat_bytes = 16'd3;
            default: beat_bytes = 16'd4;
        endcase
        final_hit = (rem_q <= beat_bytes);
        pay_keep  = ip_keep_in;
        if (final_hit) begin
            case (rem_q[2:0])
                3'd1:    pay_keep = 4'b1000;
                3'd2:    pay_keep = 4'b1100;
                3'd3:    pay_keep = 4'b1110;
                default: pay_keep = ip_keep_in;
            endcase
        end
    end

    // Bytes beyond the trimmed keep are padding; present them as zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign byte_mask[8*gi +: 8] = {8{pay_keep[gi]}};
    end
    assign pay_data = ip_data_in & byte_mask;
`else
    assign pay_keep = ip_keep_in;
    assign pay_data = ip_data_in;
`endif

    // In S_PAY the single output register gates acceptance; elsewhere the
    // input is always drained.
    assign ip_ready_out = (state_q == S_PAY) ? (!dvalid_q || data_ready_in) : 1'b1;
    assign accept       = ip_valid_in && ip_ready_out;
    assign udp_len      = ip_data_in[31:16];

    always_comb begin
        state_d     = state_q;
        pend_port_d = pend_port_q;
        pend_ip_d   = pend_ip_q;
        port_ok_d   = port_ok_q;
        src_ip_d    = src_ip_q;
        src_port_d  = src_port_q;
        length_d    = length_q;
        hdr_valid_d = 1'b0;
        err_d       = 1'b0;
        data_d      = data_q;
        keep_d      = keep_q;
        last_d      = last_q;
        dvalid_d    = dvalid_q && !data_ready_in;
        drop_inc    = 1'b0;
`ifdef UDP_LEN_CHECK_EN
        rem_d       = rem_q;
`endif
        case (state_q)
            S_HDR0: begin
                if (accept) begin
                    pend_port_d = ip_data_in[31:16];
                    pend_ip_d   = src_ip_addr_in;
                    port_ok_d   = !PORT_FILTER || (ip_data_in[15:0] == local_port_in);
                    if (ip_last_in) begin
                        // One-word datagram cannot hold a UDP header.
                        err_d    = 1'b1;
                        drop_inc = 1'b1;
                    end else begin
                        state_d = S_HDR1;
                    end
                end
            end
            S_HDR1: begin
                if (accept) begin
                    if (udp_len < 16'd8 || (ip_last_in && udp_len > 16'd8)) begin
                        err_d    = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = ip_last_in ? S_HDR0 : S_DROP;
                    end else if (!port_ok_q) begin
                        drop_inc = 1'b1;
                        state_d  = ip_last_in ? S_HDR0 : S_DROP;
                    end else begin
                        hdr_valid_d = 1'b1;
                        src_ip_d    = pend_ip_q;
                        src_port_d  = pend_port_q;
                        length_d    = udp_len - 16'd8;
`ifdef UDP_LEN_CHECK_EN
                        rem_d       = udp_len - 16'd8;
`endif
                        if (udp_len == 16'd8)
                            state_d = ip_last_in ? S_HDR0 : S_DROP;
                        else
                            state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (accept) begin
                    dvalid_d = 1'b1;
                    data_d   = pay_data;
                    keep_d   = pay_keep;
`ifdef UDP_LEN_CHECK_EN
                    if (final_hit) begin
                        last_d  = 1'b1;
                        rem_d   = 16'd0;
                        state_d = ip_last_in ? S_HDR0 : S_DROP;
                    end else begin
                        last_d = ip_last_in;
                        rem_d  = rem_q - beat_bytes;
                        if (ip_last_in) begin
                            // Truncated datagram: deliver what arrived, flag it.
                            err_d   = 1'b1;
                            state_d = S_HDR0;
                        end
                    end
`else
                    last_d = ip_last_in;
                    if (ip_last_in)
                        state_d = S_HDR0;
`endif
                end
            end
            default: begin
                if (accept && ip_last_in)
                    state_d = S_HDR0;
            end
        endcase
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && drop_cnt_q != {DROP_CNT_W{1'b1}})
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_HDR0;
            pend_port_q <= '0;
            pend_ip_q   <= '0;
            port_ok_q   <= 1'b0;
            src_ip_q    <= '0;
            src_port_q  <= '0;
            length_q    <= '0;
            hdr_valid_q <= 1'b0;
            err_q       <= 1'b0;
            drop_cnt_q  <= '0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            dvalid_q    <= 1'b0;
`ifdef UDP_LEN_CHECK_EN
            rem_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_port_q <= pend_port_d;
            pend_ip_q   <= pend_ip_d;
            port_ok_q   <= port_ok_d;
            src_ip_q    <= src_ip_d;
            src_port_q  <= src_port_d;
            length_q    <= length_d;
            hdr_valid_q <= hdr_valid_d;
            err_q       <= err_d;
            drop_cnt_q  <= drop_cnt_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            dvalid_q    <= dvalid_d;
`ifdef UDP_LEN_CHECK_EN
            rem_q       <= rem_d;
`endif
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = dvalid_q;
    assign data_keep_out  = keep_q;
    assign data_last_out  = last_q;
    assign hdr_valid_out  = hdr_valid_q;
    assign src_ip_out     = src_ip_q;
    assign src_port_out   = src_port_q;
    assign length_out     = length_q;
    assign err_out        = err_q;
    assign drop_cnt_out   = drop_cnt_q;

endmodule
